// File: rtl/div_unit.sv
// div_unit: sequential signed 32-bit divider (MIPS DIV) for the multicycle datapath.
// Restoring shift-subtract on operand magnitudes, sign fix on the completing edge.
// Quotient -> Lo, remainder -> Hi. Optional macro DIV_ZERO_TRAP_EN enables the
// early divide-by-zero exit and the DivZero flag; without it DivZero is always 0
// and B==0 yields Lo=32'hFFFFFFFF, Hi=A after the full 32 iterations.
module div_unit #(
  parameter logic [5:0] STATE_DIV  = 6'd38,
  parameter logic [5:0] STATE_DIV2 = 6'd39
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  State,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        EndDivFlag,
  output logic        DivZero
);

  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        busy_q, busy_d;
  logic        bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        end_q, end_d;
  logic        dz_q, dz_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] sh_rem, step_rem;
  logic [31:0] sh_quo, step_quo;
  logic        fits;

  // Operand magnitudes; 32'h80000000 maps to itself, read as unsigned.
  assign abs_a = A[31] ? (32'd0 - A) : A;
  assign abs_b = B[31] ? (32'd0 - B) : B;

  // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
  // The partial remainder is always below dvs, so rem_q[32] is 0 before the shift.
  assign sh_rem   = {rem_q[31:0], quo_q[31]};
  assign sh_quo   = {quo_q[30:0], 1'b0};
  assign fits     = (sh_rem >= {1'b0, dvs_q});
  assign step_rem = fits ? (sh_rem - {1'b0, dvs_q}) : sh_rem;
  assign step_quo = {sh_quo[31:1], fits};

  // Next-state logic: load on DIV, iterate on DIV2 while busy, hold otherwise.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    bzero_d = bzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    end_d   = end_q;
    dz_d    = dz_q;
    if (State == STATE_DIV) begin
      rem_d   = 33'd0;
      quo_d   = abs_a;
      dvs_d   = abs_b;
      cnt_d   = 6'd0;
      qneg_d  = A[31] ^ B[31];
      rneg_d  = A[31];
      bzero_d = (B == 32'd0);
      busy_d  = 1'b1;
      end_d   = 1'b0;
      dz_d    = 1'b0;
    end else if (State == STATE_DIV2 && busy_q) begin
`ifdef DIV_ZERO_TRAP_EN
      if (bzero_q) begin
        dz_d   = 1'b1;
        end_d  = 1'b1;
        busy_d = 1'b0;
      end else
`endif
      begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          busy_d = 1'b0;
          end_d  = 1'b1;
          // With a zero divisor every step "fits", so the raw remainder path
          // already rebuilds A; only the quotient needs forcing.
          if (bzero_q)
            lo_d = 32'hFFFF_FFFF;
          else
            lo_d = qneg_q ? (32'd0 - step_quo) : step_quo;
          hi_d = rneg_q ? (32'd0 - step_rem[31:0]) : step_rem[31:0];
        end
      end
    end
  end

  // State registers; synchronous reset has priority over State.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 6'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      end_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      bzero_q <= bzero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      end_q   <= end_d;
      dz_q    <= dz_d;
    end
  end

  assign Hi         = hi_q;
  assign Lo         = lo_q;
  assign EndDivFlag = end_q;
  assign DivZero    = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. The driver pushes the expected
// {DivZero,Hi,Lo} of every operation it runs to completion; a monitor pops and
// compares on each rising edge of EndDivFlag.
module tb_div_unit;

  localparam logic [5:0] S_DIV  = 6'd38;
  localparam logic [5:0] S_DIV2 = 6'd39;
  localparam logic [5:0] S_IDLE = 6'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  state;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        end_flag, div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];
  logic [31:0] hold_hi, hold_lo;
  logic        prev_end = 1'b0;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  div_unit #(.STATE_DIV(S_DIV), .STATE_DIV2(S_DIV2)) dut (
    .Clk(clk), .Reset(rst), .State(state), .A(a), .B(b),
    .Hi(hi), .Lo(lo), .EndDivFlag(end_flag), .DivZero(div_zero)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed truncating division with plain 64-bit arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] qv, rv;
    if (y == 32'd0) begin
      if (TRAP) return {1'b1, h, l};
      return {1'b0, x, 32'hFFFF_FFFF};
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    qv = q;
    rv = r;
    return {1'b0, rv[31:0], qv[31:0]};
  endfunction

  // monitor: compare on each completion
  always @(negedge clk) begin
    if (end_flag && !prev_end) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 65'd1, 65'd0);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("result", {div_zero, hi, lo}, e);
      end
    end
    prev_end = end_flag;
  end

  task automatic step(input logic [5:0] st);
    state = st;
    @(posedge clk);
    #1;
  endtask

  // Full operation, optional idle gap mid-run; checks timing and holding.
  task automatic run_full(input logic [31:0] x, input logic [31:0] y, input bit gap);
    logic [64:0] e;
    int lat;
    e = ref_div(x, y, hold_hi, hold_lo);
    lat = (TRAP && y == 32'd0) ? 1 : 32;
    exp_q.push_back(e);
    a = x;
    b = y;
    step(S_DIV);
    chk("end_cleared_on_load", {64'd0, end_flag}, 65'd0);
    for (int k = 1; k <= lat; k++) begin
      if (gap && k == 10) begin
        step(S_IDLE);
        step(S_IDLE);
        chk("end_during_gap", {64'd0, end_flag}, 65'd0);
      end
      a = $urandom;
      b = $urandom;
      step(S_DIV2);
      if (k < lat) begin
        chk("end_early", {64'd0, end_flag}, 65'd0);
        chk("hold_hilo", {1'b0, hi, lo}, {1'b0, hold_hi, hold_lo});
      end else begin
        chk("end_on_time", {64'd0, end_flag}, 65'd1);
      end
    end
    hold_hi = e[63:32];
    hold_lo = e[31:0];
    step(S_DIV2);
    step(S_IDLE);
    chk("after_done", {end_flag, hi, lo}, {1'b1, hold_hi, hold_lo});
  endtask

  initial begin
    logic [31:0] x, y;
    rst = 1'b1;
    state = S_IDLE;
    a = 32'd0;
    b = 32'd0;
    hold_hi = 32'd0;
    hold_lo = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    step(S_IDLE);
    chk("reset_state", {div_zero, end_flag, hi, lo}, 65'd0);

    // directed cases
    run_full(32'd100, 32'd7, 1'b0);
    run_full(-32'sd7, 32'd2, 1'b0);
    run_full(32'd7, -32'sd2, 1'b0);
    run_full(-32'sd7, -32'sd2, 1'b0);
    run_full(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_full(32'd5, 32'd0, 1'b0);
    run_full(32'd123456, 32'd0, 1'b0);
    run_full(32'hDEAD_BEEF, 32'd1000, 1'b1);

    // reset after 10 DIV2 cycles
    a = 32'd1000;
    b = 32'd3;
    step(S_DIV);
    for (int k = 0; k < 10; k++) step(S_DIV2);
    rst = 1'b1;
    step(S_DIV2);
    rst = 1'b0;
    chk("reset_mid_op", {div_zero, end_flag, hi, lo}, 65'd0);
    hold_hi = 32'd0;
    hold_lo = 32'd0;
    step(S_DIV2);
    chk("no_resume_after_reset", {64'd0, end_flag}, 65'd0);

    // restart mid-operation
    a = 32'd77777;
    b = 32'd13;
    step(S_DIV);
    for (int k = 0; k < 12; k++) step(S_DIV2);
    run_full(32'd9, 32'd3, 1'b0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 9);
        2: y = 32'd0 - $urandom_range(1, 9);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFF_FFFF;
      run_full(x, y, ($urandom_range(0, 3) == 0));
    end

    step(S_IDLE);
    chk("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
